// File: rtl/aes_enc_pkg.sv
// Shared AES-128 tables, FSM encoding and round-transform functions for aes_encrypter.
package aes_enc_pkg;

  localparam int NR    = 10;
  localparam int BLK_W = 128;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Entry 0 is unused: the round counter starts at 1.
  localparam logic [0:10][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] get_rcon(input logic [3:0] rnd);
    return (rnd <= 4'(NR)) ? RCON[rnd] : 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [BLK_W-1:0] sub_bytes(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte i sits at bits [127-8i -: 8]; row = i%4, column = i/4.
  function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[BLK_W-1-8*(4*c+r) -: 8] = s[BLK_W-1-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[BLK_W-1-32*c -: 8];
      a1 = s[BLK_W-9-32*c -: 8];
      a2 = s[BLK_W-17-32*c -: 8];
      a3 = s[BLK_W-25-32*c -: 8];
      o[BLK_W-1-32*c -: 8]  = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[BLK_W-9-32*c -: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[BLK_W-17-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[BLK_W-25-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_encrypter_key_step.sv
// Combinational AES-128 key schedule step: round key r-1 plus Rcon[r] gives round key r.
module aes_key_step
  import aes_enc_pkg::*;
(
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  output logic [127:0] rk_next
);

  logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

  always_comb begin
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    // SubWord(RotWord(w3)) with Rcon folded into the leading byte
    t  = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    rk_next = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_encrypter.sv
// Iterative AES-128 encrypter, one round per clock, valid/ready on both sides.
// Optional one-entry output register: define AES_ENC_OUT_BUF_EN.
module aes_encrypter
  import aes_enc_pkg::*;
#(
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [127:0]         key,
  input  logic                 valid_key,
  input  logic [127:0]         data_in,
  input  logic                 valid_in,
  output logic                 ready_in,
  output logic [127:0]         data_out,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [BLK_CNT_W-1:0] blk_cnt
);

  fsm_t             fsm;
  logic             key_loaded;
  logic             out_vld;
  logic [3:0]       rnd;
  logic [BLK_W-1:0] k0, rk, st, rk_next, sr, round_out;
  logic [7:0]       rcon_cur;
  logic             accept, key_ld, step, last_round, stall;
`ifdef AES_ENC_OUT_BUF_EN
  logic [BLK_W-1:0] out_buf;
`endif

  assign ready_in   = (fsm == IDLE) & key_loaded & ~valid_key;
  assign accept     = ready_in & valid_in;
  assign key_ld     = (fsm == IDLE) & valid_key;
  assign last_round = (rnd == 4'(NR));
`ifdef AES_ENC_OUT_BUF_EN
  // Round 10 waits while the output register still holds an undelivered block
  assign stall = last_round & out_vld & ~ready_out;
`else
  assign stall = 1'b0;
`endif
  assign step     = (fsm == ROUND) & ~stall;
  assign rcon_cur = get_rcon(rnd);

  aes_key_step u_key_step (
    .rk      (rk),
    .rcon    (rcon_cur),
    .rk_next (rk_next)
  );

  always_comb begin
    sr        = shift_rows(sub_bytes(st));
    round_out = (last_round ? sr : mix_columns(sr)) ^ rk_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= IDLE;
      key_loaded <= 1'b0;
      out_vld    <= 1'b0;
      blk_cnt    <= '0;
      rnd        <= '0;
      st         <= '0;
`ifdef AES_ENC_OUT_BUF_EN
      out_buf    <= '0;
`endif
    end else begin
      if (out_vld && ready_out) begin
        blk_cnt <= blk_cnt + 1'b1;
        out_vld <= 1'b0;
      end
      if (accept) st <= data_in ^ k0;
      else if (step) st <= round_out;
      case (fsm)
        IDLE: begin
          if (key_ld) key_loaded <= 1'b1;
          if (accept) begin
            rnd <= 4'd1;
            fsm <= ROUND;
          end
        end
        ROUND: begin
          if (step) begin
            rnd <= rnd + 4'd1;
            if (last_round) begin
              out_vld <= 1'b1;
`ifdef AES_ENC_OUT_BUF_EN
              out_buf <= round_out;
              fsm     <= IDLE;
`else
              fsm     <= DONE;
`endif
            end
          end
        end
        DONE: if (ready_out) fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
  end

  // Key material: each block restarts expansion from the stored round key 0
  always_ff @(posedge clk) begin
    if (key_ld) k0 <= key;
    if (accept) rk <= k0;
    else if (step) rk <= rk_next;
  end

  assign valid_out = out_vld;
`ifdef AES_ENC_OUT_BUF_EN
  assign data_out = out_buf;
`else
  assign data_out = st;
`endif

endmodule
